seq_multiplier: RTL and testbench

- Sequential radix-2 shift-add unsigned multiplier. Fixed latency; one partial-product bit per clock.
- Uses the same start/done operand handshake as the divider. Sits beside it in the arithmetic unit.
- Its main use is as the inverse operation: rebuilding dividend = quotient × divisor + remainder to check divider results.

---
 rtl/seq_multiplier_pkg.sv | 12 +
 rtl/seq_multiplier.sv | 77 +++++++
 tb/tb_seq_multiplier.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared arithmetic-unit definitions: operation FSM encoding and default operand width.
package seq_multiplier_pkg;

  localparam int ARITH_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per clock, WIDTH cycles
// from accept to a one-cycle done pulse; the product holds until the next completion.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand_r;
  logic [2*WIDTH:0] acc;
  logic [WIDTH:0]   upper;
  logic [2*WIDTH:0] acc_shift;

  // High half accumulates with a WIDTH+1 bit adder so the carry survives the shift.
  always_comb begin
    upper     = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand_r}) : acc[2*WIDTH:WIDTH];
    acc_shift = {upper, acc[WIDTH-1:0]} >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand_r <= multiplicand;
            acc     <= {{(WIDTH+1){1'b0}}, multiplier};
            count   <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_shift;
          count <= count + 1'b1;
          if (count == LAST) product <= acc_shift[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=32): latency, done pulse, carry, ignored
// start, back-to-back throughput, mid-operation reset and a divider cross-check.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts negedges (from just after the accepting edge) until done, bounded.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    multiplicand = a; multiplier = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    multiplicand = $urandom; multiplier = $urandom;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp);
    int n, bc;
    launch(a, b);
    wait_done(n, bc);
    chk({tag, " latency"}, 64'(n), 64'd32);
    chk({tag, " busy_cycles"}, 64'(bc), 64'd32);
    chk({tag, " product"}, product, exp);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " product_hold"}, product, exp);
  endtask

  initial begin
    int n, bc, dcount;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset done", 64'(done), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset product", product, 64'd0);

    run("10x7", 32'd10, 32'd7, 64'd70);
    run("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run("100x0", 32'd100, 32'd0, 64'd0);
    run("0x100", 32'd0, 32'd100, 64'd0);

    // 5x5 with an ignored start of 9x9 during the third BUSY cycle
    launch(32'd5, 32'd5);
    @(negedge clk); @(negedge clk);
    multiplicand = 32'd9; multiplier = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    chk("ignored_start latency", 64'(n), 64'd29);
    chk("ignored_start product", product, 64'd25);
    // back-to-back: start during the DONE cycle
    multiplicand = 32'd9; multiplier = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b held_product", product, 64'd25);
    wait_done(n, bc);
    chk("b2b done_spacing", 64'(n + 1), 64'd33);
    chk("b2b product", product, 64'd81);
    @(negedge clk);
    chk("b2b done_pulse", 64'(done), 64'd0);

    // reset in BUSY cycle 16 of 1000x1000
    launch(32'd1000, 32'd1000);
    repeat (15) @(negedge clk);
    chk("pre_rst busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst done", 64'(done), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst product", product, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      @(negedge clk);
    end
    chk("rst no_done", 64'(dcount), 64'd0);
    run("3x4", 32'd3, 32'd4, 64'd12);

    // divider cross-check: 100 / 7 -> q=14 r=2
    run("14x7", 32'd14, 32'd7, 64'd98);
    chk("div_rebuild", product + 64'd2, 64'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
